// File: rtl/uart_rx_framed_if.sv
// Receive-side bundle from uart_rx_framed to the byte consumer.
// master = receiver (drives), slave = consumer (observes).
interface uart_rx_framed_if #(
  parameter int g_Data_Bits = 8
);
  logic                   o_RX_DV;
  logic [g_Data_Bits-1:0] o_RX_Byte;
  logic                   o_Parity_Err;
  logic                   o_Frame_Err;
  logic                   o_Break;
  logic                   o_Busy;

  modport master (
    output o_RX_DV,
    output o_RX_Byte,
    output o_Parity_Err,
    output o_Frame_Err,
    output o_Break,
    output o_Busy
  );

  modport slave (
    input o_RX_DV,
    input o_RX_Byte,
    input o_Parity_Err,
    input o_Frame_Err,
    input o_Break,
    input o_Busy
  );
endinterface

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: 5..9 data bits, optional parity, 1/2 stop bits,
// 3-sample majority per bit, parity/framing/break reporting.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low
// START     | validating start bit; high majority aborts as a glitch
// DATA      | shifting data bits into the shadow register, LSB first
// PARITY    | checking the parity bit against the data ones count
// STOP      | sampling stop bit(s); commit on the last stop sample
// WAIT_HIGH | frame error seen, hold off until the line returns high
module uart_rx_framed #(
  parameter int g_System_Clk = 100_000_000,
  parameter int g_Baud_Rate  = 9600,
  parameter int g_Data_Bits  = 8,
  parameter int g_Parity     = 0,
  parameter int g_Stop_Bits  = 1
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  input  logic            i_RX,
  uart_rx_framed_if.master rx_if
);

  localparam int c_Bit_Limit = g_System_Clk / g_Baud_Rate - 1;
  localparam int c_Half      = c_Bit_Limit / 2;
  localparam int c_Cnt_W     = $clog2(c_Bit_Limit + 1);
  localparam int c_Idx_W     = (g_Data_Bits > 1) ? $clog2(g_Data_Bits) : 1;

  localparam logic [c_Cnt_W-1:0] c_Samp_1  = c_Cnt_W'(c_Half - 1);
  localparam logic [c_Cnt_W-1:0] c_Samp_2  = c_Cnt_W'(c_Half);
  localparam logic [c_Cnt_W-1:0] c_Samp_3  = c_Cnt_W'(c_Half + 1);
  localparam logic [c_Cnt_W-1:0] c_Lim     = c_Cnt_W'(c_Bit_Limit);
  localparam logic [c_Idx_W-1:0] c_Idx_End = c_Idx_W'(g_Data_Bits - 1);
  localparam logic               c_Stop_End = 1'(g_Stop_Bits - 1);

  if (c_Bit_Limit < 7) begin : g_chk_limit
    $error("uart_rx_framed: c_Bit_Limit must be >= 7");
  end
  if (g_Data_Bits < 5 || g_Data_Bits > 9) begin : g_chk_bits
    $error("uart_rx_framed: g_Data_Bits must be 5..9");
  end
  if (g_Parity < 0 || g_Parity > 2) begin : g_chk_par
    $error("uart_rx_framed: g_Parity must be 0, 1 or 2");
  end
  if (g_Stop_Bits < 1 || g_Stop_Bits > 2) begin : g_chk_stop
    $error("uart_rx_framed: g_Stop_Bits must be 1 or 2");
  end

  typedef enum logic [2:0] {
    s_idle,
    s_start,
    s_data,
    s_parity,
    s_stop,
    s_wait_high
  } state_t;

  state_t state, state_nx;

  logic                   rx_meta, rx_s;
  logic [c_Cnt_W-1:0]     cnt;
  logic [c_Idx_W-1:0]     idx;
  logic                   stop_idx;
  logic                   samp_a, samp_b;
  logic                   maj;
  logic                   at_samp, at_end;
  logic                   commit;
  logic                   frame_start;
  logic                   bit_run;
  logic [g_Data_Bits-1:0] shadow;
  logic                   par_acc;
  logic                   par_err;
  logic                   frm_err;
  logic                   any_one;

  logic                   dv_q;
  logic [g_Data_Bits-1:0] byte_q;
  logic                   perr_q, ferr_q, brk_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_RX;
      rx_s    <= rx_meta;
    end
  end

  // The third sample is taken live, so the vote resolves in the c_Half+1 cycle.
  assign maj     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign at_samp = (cnt == c_Samp_3);
  assign at_end  = (cnt == c_Lim);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= s_idle;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    commit      = 1'b0;
    frame_start = 1'b0;
    case (state)
      s_idle: begin
        if (!rx_s) begin
          state_nx    = s_start;
          frame_start = 1'b1;
        end
      end
      s_start: begin
        if (at_samp && maj) state_nx = s_idle;
        else if (at_end)    state_nx = s_data;
      end
      s_data: begin
        if (at_end && idx == c_Idx_End)
          state_nx = (g_Parity != 0) ? s_parity : s_stop;
      end
      s_parity: begin
        if (at_end) state_nx = s_stop;
      end
      s_stop: begin
        if (at_samp && stop_idx == c_Stop_End) begin
          commit   = 1'b1;
          state_nx = (frm_err || !maj) ? s_wait_high : s_idle;
        end
      end
      s_wait_high: begin
        if (rx_s) state_nx = s_idle;
      end
      default: state_nx = s_idle;
    endcase
  end

  assign bit_run = (state != s_idle) && (state != s_wait_high) &&
                   (state_nx != s_idle) && (state_nx != s_wait_high);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
      samp_a   <= 1'b0;
      samp_b   <= 1'b0;
    end else begin
      if (bit_run) cnt <= at_end ? '0 : cnt + c_Cnt_W'(1);
      else         cnt <= '0;

      if (cnt == c_Samp_1) samp_a <= rx_s;
      if (cnt == c_Samp_2) samp_b <= rx_s;

      if (state == s_idle)               idx <= '0;
      else if (state == s_data && at_end) idx <= idx + c_Idx_W'(1);

      if (state == s_idle)               stop_idx <= 1'b0;
      else if (state == s_stop && at_end) stop_idx <= 1'b1;
    end
  end

  // Per-frame accumulators; cleared as the start edge is accepted.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      shadow  <= '0;
      par_acc <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      any_one <= 1'b0;
    end else if (frame_start) begin
      shadow  <= '0;
      par_acc <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      any_one <= 1'b0;
    end else if (at_samp) begin
      case (state)
        s_data: begin
          shadow[idx] <= maj;
          par_acc     <= par_acc ^ maj;
          any_one     <= any_one | maj;
        end
        s_parity: begin
          par_err <= (g_Parity == 1) ? ~(par_acc ^ maj) : (par_acc ^ maj);
          any_one <= any_one | maj;
        end
        s_stop: begin
          frm_err <= frm_err | ~maj;
          any_one <= any_one | maj;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      dv_q   <= 1'b0;
      byte_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      dv_q <= commit;
      if (commit) begin
        byte_q <= shadow;
        perr_q <= (g_Parity != 0) && par_err;
        ferr_q <= frm_err | ~maj;
        brk_q  <= ~(any_one | maj);
      end
    end
  end

  assign rx_if.o_RX_DV      = dv_q;
  assign rx_if.o_RX_Byte    = byte_q;
  assign rx_if.o_Parity_Err = perr_q;
  assign rx_if.o_Frame_Err  = ferr_q;
  assign rx_if.o_Break      = brk_q;
  assign rx_if.o_Busy       = (state != s_idle);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench for uart_rx_framed: three configurations (8N1, 8E1, 9N2)
// driven from directed frames; monitors pop expectations on every o_RX_DV.
`timescale 1ns/1ps
module tb_uart_rx_framed;

  localparam realtime c_Bit  = 160.0;
  localparam realtime c_Fast = 156.8;

  logic i_Clk = 1'b0;
  logic i_Rst_n;
  logic rx_n1 = 1'b1;
  logic rx_e1 = 1'b1;
  logic rx_92 = 1'b1;

  always #5 i_Clk = ~i_Clk;

  uart_rx_framed_if #(.g_Data_Bits(8)) if_n1 ();
  uart_rx_framed_if #(.g_Data_Bits(8)) if_e1 ();
  uart_rx_framed_if #(.g_Data_Bits(9)) if_92 ();

  uart_rx_framed #(.g_System_Clk(160), .g_Baud_Rate(10), .g_Data_Bits(8),
                   .g_Parity(0), .g_Stop_Bits(1))
    dut_n1 (.i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_RX(rx_n1), .rx_if(if_n1));
  uart_rx_framed #(.g_System_Clk(160), .g_Baud_Rate(10), .g_Data_Bits(8),
                   .g_Parity(2), .g_Stop_Bits(1))
    dut_e1 (.i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_RX(rx_e1), .rx_if(if_e1));
  uart_rx_framed #(.g_System_Clk(160), .g_Baud_Rate(10), .g_Data_Bits(9),
                   .g_Parity(0), .g_Stop_Bits(2))
    dut_92 (.i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_RX(rx_92), .rx_if(if_92));

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t q_n1[$];
  exp_t q_e1[$];
  exp_t q_92[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
  endtask

  // Busy is expected high on the DV cycle only when the frame ended in error (WAIT_HIGH).
  task automatic compare_dv(input string tag, input int qsize, input exp_t e,
                            input logic [8:0] d, input logic p, input logic f,
                            input logic b, input logic busy);
    check({tag, "_dv_expected"}, 16'(qsize > 0), 16'd1);
    if (qsize > 0) begin
      check({tag, "_byte"},  16'(d),    16'(e.data));
      check({tag, "_perr"},  16'(p),    16'(e.perr));
      check({tag, "_ferr"},  16'(f),    16'(e.ferr));
      check({tag, "_break"}, 16'(b),    16'(e.brk));
      check({tag, "_busy"},  16'(busy), 16'(e.ferr));
    end
  endtask

  always @(negedge i_Clk) begin : mon_n1
    exp_t e;
    int   sz;
    if (if_n1.o_RX_DV === 1'b1) begin
      sz = q_n1.size();
      e  = (sz > 0) ? q_n1.pop_front() : '0;
      compare_dv("n1", sz, e, {1'b0, if_n1.o_RX_Byte}, if_n1.o_Parity_Err,
                 if_n1.o_Frame_Err, if_n1.o_Break, if_n1.o_Busy);
    end
  end

  always @(negedge i_Clk) begin : mon_e1
    exp_t e;
    int   sz;
    if (if_e1.o_RX_DV === 1'b1) begin
      sz = q_e1.size();
      e  = (sz > 0) ? q_e1.pop_front() : '0;
      compare_dv("e1", sz, e, {1'b0, if_e1.o_RX_Byte}, if_e1.o_Parity_Err,
                 if_e1.o_Frame_Err, if_e1.o_Break, if_e1.o_Busy);
    end
  end

  always @(negedge i_Clk) begin : mon_92
    exp_t e;
    int   sz;
    if (if_92.o_RX_DV === 1'b1) begin
      sz = q_92.size();
      e  = (sz > 0) ? q_92.pop_front() : '0;
      compare_dv("n92", sz, e, if_92.o_RX_Byte, if_92.o_Parity_Err,
                 if_92.o_Frame_Err, if_92.o_Break, if_92.o_Busy);
    end
  end

  task automatic set_line(input int ch, input logic v);
    case (ch)
      0:       rx_n1 = v;
      1:       rx_e1 = v;
      default: rx_92 = v;
    endcase
  endtask

  // bits[0] is the start bit; the line returns high after the last bit.
  task automatic send(input int ch, input logic [15:0] bits, input int n, input realtime bt);
    for (int i = 0; i < n; i++) begin
      set_line(ch, bits[i]);
      #(bt);
    end
    set_line(ch, 1'b1);
  endtask

  task automatic idle(input int nbits);
    #(nbits * c_Bit);
  endtask

  function automatic exp_t mk(input logic [8:0] d, input logic p, input logic f, input logic b);
    exp_t e;
    e.data = d;
    e.perr = p;
    e.ferr = f;
    e.brk  = b;
    return e;
  endfunction

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    i_Rst_n = 1'b0;
    #2;
    repeat (3) @(posedge i_Clk);
    #1;
    check("rst_n1_dv",   16'(if_n1.o_RX_DV),      16'd0);
    check("rst_n1_byte", 16'(if_n1.o_RX_Byte),    16'd0);
    check("rst_n1_perr", 16'(if_n1.o_Parity_Err), 16'd0);
    check("rst_n1_ferr", 16'(if_n1.o_Frame_Err),  16'd0);
    check("rst_n1_brk",  16'(if_n1.o_Break),      16'd0);
    check("rst_n1_busy", 16'(if_n1.o_Busy),       16'd0);
    check("rst_92_byte", 16'(if_92.o_RX_Byte),    16'd0);
    i_Rst_n = 1'b1;
    idle(2);

    // 8N1 0xA5
    q_n1.push_back(mk(9'h0A5, 1'b0, 1'b0, 1'b0));
    send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, c_Bit);
    idle(1);
    check("t1_busy_after", 16'(if_n1.o_Busy), 16'd0);

    // 8E1 0x07: three ones, parity bit 1 is correct, parity bit 0 is wrong
    q_e1.push_back(mk(9'h007, 1'b0, 1'b0, 1'b0));
    send(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, c_Bit);
    idle(2);
    q_e1.push_back(mk(9'h007, 1'b1, 1'b0, 1'b0));
    send(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, c_Bit);
    idle(2);

    // 3-clock glitch must not produce a frame
    rx_n1 = 1'b0;
    #30;
    rx_n1 = 1'b1;
    idle(2);
    check("t3_glitch_idle", 16'(if_n1.o_Busy), 16'd0);
    q_n1.push_back(mk(9'h03C, 1'b0, 1'b0, 1'b0));
    send(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, c_Bit);
    idle(2);

    // Break: 20 bit times low, one DV only, parked in WAIT_HIGH
    q_n1.push_back(mk(9'h000, 1'b0, 1'b1, 1'b1));
    rx_n1 = 1'b0;
    idle(15);
    check("t4_wait_high_busy", 16'(if_n1.o_Busy), 16'd1);
    idle(5);
    rx_n1 = 1'b1;
    idle(2);
    check("t4_released_idle", 16'(if_n1.o_Busy), 16'd0);
    q_n1.push_back(mk(9'h055, 1'b0, 1'b0, 1'b0));
    send(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, c_Bit);
    idle(2);

    // 9-bit, 2 stop bits, second stop bit low
    q_92.push_back(mk(9'h1AB, 1'b0, 1'b1, 1'b0));
    send(2, {4'b0, 1'b0, 1'b1, 9'h1AB, 1'b0}, 12, c_Bit);
    idle(2);

    // Reset in data bit 4 of 0xF0: start + four zero data bits, then bit 4 high
    send(0, 16'h0000, 5, c_Bit);
    #(c_Bit / 2);
    i_Rst_n = 1'b0;
    #1;
    check("t6_rst_n1_byte", 16'(if_n1.o_RX_Byte),    16'd0);
    check("t6_rst_n1_busy", 16'(if_n1.o_Busy),       16'd0);
    check("t6_rst_n1_dv",   16'(if_n1.o_RX_DV),      16'd0);
    check("t6_rst_e1_perr", 16'(if_e1.o_Parity_Err), 16'd0);
    check("t6_rst_92_ferr", 16'(if_92.o_Frame_Err),  16'd0);
    check("t6_rst_92_byte", 16'(if_92.o_RX_Byte),    16'd0);
    #50;
    i_Rst_n = 1'b1;
    idle(2);

    // Three back-to-back 0x0F frames, 2% fast
    for (int k = 0; k < 3; k++) q_n1.push_back(mk(9'h00F, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) send(0, {6'b0, 1'b1, 8'h0F, 1'b0}, 10, c_Fast);
    idle(3);

    for (int i = 0; i < 5000 && (q_n1.size() + q_e1.size() + q_92.size()) != 0; i++)
      @(posedge i_Clk);
    check("drain_n1", 16'(q_n1.size()), 16'd0);
    check("drain_e1", 16'(q_e1.size()), 16'd0);
    check("drain_92", 16'(q_92.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
